uart_rx_fifo: RTL and testbench

- Serial receive front-end on the direct-connect UART pin (`rxd`). Sits directly upstream of the UART AXI controller, which pops bytes from it.
- Synchronises the asynchronous `rxd` line and deframes 8N1 characters using 16x oversampling.
- Buffers received bytes in a show-ahead FIFO with a valid/ready pop interface.
- Reports framing and overrun errors as sticky flags for the controller's status register.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/uart_rx_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART receive path.
//               rx_state_t   - receiver FSM state encoding
//               OVERSAMPLE   - oversample ticks per bit
//               uart_div()   - clock cycles per oversample tick
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Integer division; a result below 1 means the line rate is unreachable.
    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO. The head entry is always
//               presented on o_dout (forced to zero while empty).
//               A push into a full FIFO is accepted only when a pop happens
//               in the same cycle; otherwise it is dropped and the contents
//               are left untouched. A pop while empty is ignored.
// Ports       : clk, reset_n (synchronous, active low)
//               i_push/i_din  - write strobe and data
//               i_pop         - read strobe (pops the head)
//               o_dout        - head entry
//               o_count       - occupancy, 0..DEPTH
//               o_full/o_empty
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0] c_ONE  = (c_AW + 1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_dout  = o_empty ? '0 : r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver with 16x oversampling feeding a
//               show-ahead FIFO, plus sticky framing/overrun flags.
//               Optional build macro UART_RX_MAJORITY_EN: each bit decision
//               takes the majority of three consecutive oversample ticks
//               ending at the mid-bit decision tick instead of one sample.
//               State transitions happen on the same ticks in both builds.
// Ports       : clk, reset_n (synchronous, active low)
//               rxd        - asynchronous serial input, idles high
//               rx_data    - FIFO head byte (valid while rx_valid=1)
//               rx_valid   - FIFO not empty
//               rx_ready   - pop strobe, effective when rx_valid=1
//               rx_count   - FIFO occupancy
//               frame_err  - sticky, stop bit sampled low
//               overrun    - sticky, byte dropped on a full FIFO
//               err_clr    - clears both sticky flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr
);

    localparam int c_DIV  = uart_div(CLK_FREQ, BAUD);
    localparam int c_DIVW = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_DIVW-1:0] c_DIV_LAST = c_DIVW'(c_DIV - 1);
    localparam logic [c_DIVW-1:0] c_DIV_ONE  = c_DIVW'(1);

    if (c_DIV < 1) begin : g_div_check
        $error("uart_rx_fifo: CLK_FREQ too low for BAUD with 16x oversampling");
    end

    // Two-flop synchroniser plus one delay stage for edge detection.
    logic       r_sync1;
    logic       r_rxd_s;
    logic       r_rxd_s_d;

    rx_state_t        r_state;
    logic [c_DIVW-1:0] r_div;
    logic [3:0]       r_tcnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
    logic             r_overrun;

    logic w_start;
    logic w_tick;
    logic w_bit;
    logic w_stop_tick;
    logic w_push;
    logic w_ferr;
    logic w_ovr;
    logic w_full;
    logic w_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_rxd_s   <= 1'b1;
            r_rxd_s_d <= 1'b1;
        end else begin
            r_sync1   <= rxd;
            r_rxd_s   <= r_sync1;
            r_rxd_s_d <= r_rxd_s;
        end
    end

    assign w_start = (r_state == IDLE) && r_rxd_s_d && !r_rxd_s;
    assign w_tick  = (r_div == c_DIV_LAST);

    // Divider restarts on the detected edge so ticks are phase-aligned to it.
    always_ff @(posedge clk) begin
        if (!reset_n || w_start || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_ONE;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hist <= 2'b11;
        end else if (w_tick) begin
            r_hist <= {r_hist[0], r_rxd_s};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rxd_s) | (r_hist[0] & r_rxd_s);
`else
    assign w_bit = r_rxd_s;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_tcnt    <= 4'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= START;
                        r_tcnt  <= 4'd0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd7) begin
                            // Mid start bit: a high line here was only a glitch.
                            r_tcnt <= 4'd0;
                            if (w_bit) begin
                                r_state <= IDLE;
                            end else begin
                                r_state   <= DATA;
                                r_bit_idx <= 3'd0;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_tcnt <= r_tcnt + 4'd1;
                        if (r_tcnt == 4'd15) begin
                            r_shift[r_bit_idx] <= w_bit;
                            r_bit_idx          <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_tcnt <= r_tcnt + 4'd1;
                        if (r_tcnt == 4'd15) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_stop_tick = (r_state == STOP) && w_tick && (r_tcnt == 4'd15);
    assign w_push      = w_stop_tick & w_bit;
    assign w_ferr      = w_stop_tick & ~w_bit;
    // When full, rx_valid is necessarily 1, so rx_ready alone decides the pop.
    assign w_ovr       = w_push & w_full & ~rx_ready;

    // A new error event takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovr) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_din   (r_shift),
        .i_pop   (rx_ready),
        .o_dout  (rx_data),
        .o_count (rx_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_valid  = ~w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo at 16 clk per bit with
//               a 4-entry FIFO. Bytes expected in the FIFO are queued when
//               their frame is driven and compared as they are popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_DEPTH = 4;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      rxd;
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic [$clog2(c_DEPTH):0]  rx_count;
    logic                      frame_err;
    logic                      overrun;
    logic                      err_clr;

    int         n_vec = 0;
    int         n_err = 0;
    int         rise_off;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(
        .CLK_FREQ   (16000000),
        .BAUD       (1000000),
        .FIFO_DEPTH (c_DEPTH)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every accepted pop must deliver the oldest expected byte.
    always @(negedge clk) begin
        if (reset_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("sb_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drives one 160-clock 8N1 frame starting in the posedge+1 phase.
    // Optional per-offset actions: one-cycle pop, one-cycle reset, high glitch.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_push,
                              input int ready_at, input int rst_at, input int glitch_at);
        logic [9:0] frame;
        logic       v_prev;
        frame = {stop_bit, b, 1'b0};
        if (expect_push) exp_q.push_back(b);
        rise_off = -1;
        v_prev   = rx_valid;
        for (int i = 0; i < 160; i++) begin
            rxd = (i == glitch_at) ? 1'b1 : frame[i / 16];
            if (ready_at >= 0 && i == ready_at) rx_ready = 1'b1;
            if (ready_at >= 0 && i == ready_at + 1) rx_ready = 1'b0;
            if (rst_at >= 0 && i == rst_at) reset_n = 1'b0;
            if (rst_at >= 0 && i == rst_at + 1) reset_n = 1'b1;
            @(negedge clk);
            if (rst_at >= 0 && i == rst_at + 1) begin
                chk("rst_mid_valid", 32'(rx_valid), 32'd0);
                chk("rst_mid_count", 32'(rx_count), 32'd0);
                chk("rst_mid_data", 32'(rx_data), 32'd0);
                chk("rst_mid_ferr", 32'(frame_err), 32'd0);
                chk("rst_mid_ovr", 32'(overrun), 32'd0);
            end
            if (rx_valid && !v_prev && rise_off < 0) rise_off = i;
            v_prev = rx_valid;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_n(input int n);
        rx_ready = 1'b1;
        step(n);
        rx_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rxd      = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        reset_n  = 1'b0;
        step(3);
        @(negedge clk);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_count", 32'(rx_count), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(10);

        // Single byte, observe push latency from the falling start edge.
        send_frame(8'hA5, 1'b1, 1'b1, -1, -1, -1);
        chk("a5_latency", 32'(rise_off), 32'd155);
        @(negedge clk);
        chk("a5_valid", 32'(rx_valid), 32'd1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_count", 32'(rx_count), 32'd1);
        chk("a5_ferr", 32'(frame_err), 32'd0);
        chk("a5_ovr", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        pop_n(1);
        @(negedge clk);
        chk("a5_drained", 32'(rx_valid), 32'd0);
        @(posedge clk); #1;

        // Framing error followed by a break held low.
        send_frame(8'h00, 1'b0, 1'b0, -1, -1, -1);
        step(40);
        @(negedge clk);
        chk("brk_ferr", 32'(frame_err), 32'd1);
        chk("brk_count", 32'(rx_count), 32'd0);
        @(posedge clk); #1;
        clr_pulse();
        @(negedge clk);
        chk("brk_clr", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        step(200);
        @(negedge clk);
        chk("brk_no_second", 32'(frame_err), 32'd0);
        chk("brk_count2", 32'(rx_count), 32'd0);
        @(posedge clk); #1;
        rxd = 1'b1;
        step(20);

        // Overflow: fifth byte dropped.
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, (k <= c_DEPTH), -1, -1, -1);
        end
        @(negedge clk);
        chk("ovf_count", 32'(rx_count), 32'd4);
        chk("ovf_flag", 32'(overrun), 32'd1);
        chk("ovf_head", 32'(rx_data), 32'h01);
        @(posedge clk); #1;
        pop_n(4);
        @(negedge clk);
        chk("ovf_drained", 32'(rx_valid), 32'd0);
        @(posedge clk); #1;
        clr_pulse();
        @(negedge clk);
        chk("ovf_clr", 32'(overrun), 32'd0);
        @(posedge clk); #1;

        // Short low glitch on an idle line.
        rxd = 1'b0;
        step(4);
        rxd = 1'b1;
        step(40);
        @(negedge clk);
        chk("glitch_count", 32'(rx_count), 32'd0);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        chk("glitch_ovr", 32'(overrun), 32'd0);
        @(posedge clk); #1;

        // Full FIFO, pop coincides with the fifth push.
        for (int k = 0; k < 4; k++) begin
            send_frame(8'h11 + 8'(k), 1'b1, 1'b1, -1, -1, -1);
        end
        send_frame(8'h15, 1'b1, 1'b1, 154, -1, -1);
        @(negedge clk);
        chk("fullpp_count", 32'(rx_count), 32'd4);
        chk("fullpp_ovr", 32'(overrun), 32'd0);
        chk("fullpp_head", 32'(rx_data), 32'h12);
        @(posedge clk); #1;
        pop_n(4);
        @(negedge clk);
        chk("fullpp_drained", 32'(rx_valid), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of data bit 4.
        send_frame(8'h5A, 1'b1, 1'b0, -1, -1, -1);
        send_frame(8'h00, 1'b0, 1'b0, -1, -1, -1);
        rxd = 1'b1;
        step(20);
        @(negedge clk);
        chk("prerst_count", 32'(rx_count), 32'd1);
        chk("prerst_ferr", 32'(frame_err), 32'd1);
        @(posedge clk); #1;
        send_frame(8'hF0, 1'b1, 1'b0, -1, 88, -1);
        step(20);
        @(negedge clk);
        chk("postrst_count", 32'(rx_count), 32'd0);
        @(posedge clk); #1;
        send_frame(8'h3C, 1'b1, 1'b1, -1, -1, -1);
        @(negedge clk);
        chk("3c_count", 32'(rx_count), 32'd1);
        chk("3c_data", 32'(rx_data), 32'h3C);
        chk("3c_ferr", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        pop_n(1);

`ifdef UART_RX_MAJORITY_EN
        // One-clock high spike at the mid-bit sample of data bit 3.
        send_frame(8'h37, 1'b1, 1'b1, -1, -1, 72);
        @(negedge clk);
        chk("maj_data", 32'(rx_data), 32'h37);
        @(posedge clk); #1;
        pop_n(1);
`endif

        step(5);
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
